// File: rtl/cost_min_tracker.sv
// cost_min_tracker
// Streaming cost evaluator for assignment-style searches. Each candidate is
// presented as N_ITEMS unsigned cost values. The block sums each candidate,
// saturating at the accumulator width. It tracks the minimum total (MinCost),
// how many candidates reached that minimum (MatchCount, saturating), and the
// index of the first candidate that reached it (MinIdx).
//
// Ports:
//   CLK, RST    clock (rising edge) and asynchronous active-high reset
//   start       begins a new session (sampled only while idle)
//   cost_valid  cost_in carries a valid item this cycle
//   cost_in     one item cost, unsigned, COST_W bits
//   cand_last   current candidate is the session's final one; sampled with
//               that candidate's last item
//   cost_ready  block accepts cost_in this cycle
//   prune       partial sum of the current candidate already exceeds MinCost
//               (informational; the candidate must still be fully delivered)
//   busy        a session is in progress
//   MinCost     minimum candidate total (all ones before any candidate)
//   MatchCount  number of candidates whose total equals MinCost
//   MinIdx      index of the first candidate that achieved MinCost
//   done        session complete; results stay valid until the next start
//   state_dbg   current FSM state (0 IDLE, 1 ACC, 2 CMP)
//
// Handshake: an item transfers on a rising edge where cost_valid=1 and
// cost_ready=1. cost_ready depends only on registered state, never on
// cost_valid. The producer may hold or drop cost_valid freely. A cycle with
// cost_ready=0 consumes nothing.
module cost_min_tracker #(
    parameter int N_ITEMS = 8,
    parameter int COST_W  = 7,
    parameter int SUM_W   = 10,
    parameter int CNT_W   = 4,
    parameter int IDX_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              cost_valid,
    input  logic [COST_W-1:0] cost_in,
    input  logic              cand_last,
    output logic              cost_ready,
    output logic              prune,
    output logic              busy,
    output logic [SUM_W-1:0]  MinCost,
    output logic [CNT_W-1:0]  MatchCount,
    output logic [IDX_W-1:0]  MinIdx,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam int ITEM_W = $clog2(N_ITEMS);
    localparam int EXT_W  = ((SUM_W > COST_W) ? SUM_W : COST_W) + 1;
    localparam logic [ITEM_W-1:0] LAST_ITEM = ITEM_W'(N_ITEMS - 1);
    localparam logic [SUM_W-1:0]  SUM_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CMP  = 2'd2
    } state_t;

    state_t             state;
    logic [SUM_W-1:0]   sum;
    logic [ITEM_W-1:0]  item;
    logic [IDX_W-1:0]   cand_idx;
    logic               found;
    logic               last_flag;

    // The sum is widened by one bit, so the carry out of the accumulator
    // is visible. Any carry clamps the sum to all ones.
    logic [EXT_W-1:0]   sum_ext;
    logic [SUM_W-1:0]   sum_next;

    assign sum_ext  = EXT_W'(sum) + EXT_W'(cost_in);
    assign sum_next = (sum_ext > EXT_W'(SUM_MAX)) ? SUM_MAX : sum_ext[SUM_W-1:0];

    assign cost_ready = (state == ACC);
    assign busy       = (state != IDLE);
    assign prune      = (state == ACC) && found && (sum > MinCost);
    assign state_dbg  = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            sum        <= '0;
            item       <= '0;
            cand_idx   <= '0;
            found      <= 1'b0;
            last_flag  <= 1'b0;
            MinCost    <= '1;
            MatchCount <= '0;
            MinIdx     <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done       <= 1'b0;
                        MinCost    <= '1;
                        MatchCount <= '0;
                        MinIdx     <= '0;
                        cand_idx   <= '0;
                        sum        <= '0;
                        item       <= '0;
                        found      <= 1'b0;
                        state      <= ACC;
                    end
                end
                ACC: begin
                    if (cost_valid) begin
                        sum  <= sum_next;
                        item <= item + ITEM_W'(1);
                        if (item == LAST_ITEM) begin
                            last_flag <= cand_last;
                            state     <= CMP;
                        end
                    end
                end
                CMP: begin
                    // The first candidate of a session always loads, even
                    // when its saturated total equals the all-ones start value.
                    if (!found || (sum < MinCost)) begin
                        MinCost    <= sum;
                        MatchCount <= CNT_W'(1);
                        MinIdx     <= cand_idx;
                        found      <= 1'b1;
                    end else if (sum == MinCost) begin
                        if (MatchCount != '1) begin
                            MatchCount <= MatchCount + CNT_W'(1);
                        end
                    end
                    if (last_flag) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        sum  <= '0;
                        item <= '0;
                        if (cand_idx != '1) begin
                            cand_idx <= cand_idx + IDX_W'(1);
                        end
                        state <= ACC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cost_min_tracker.sv
// tb_cost_min_tracker
// Self-checking bench for cost_min_tracker. Two instances share one input
// stream. dut0 uses the default widths. dut9 uses a 9-bit accumulator, so
// totals saturate at 511. A session-level reference model records each
// candidate's raw total. It derives the expected minimum, the tie count and
// the first winning index from those totals on every cycle.
module tb_cost_min_tracker;

    localparam int N = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        cost_valid;
    logic [6:0]  cost_in;
    logic        cand_last;

    logic        cost_ready0, prune0, busy0, done0;
    logic [9:0]  min0;
    logic [3:0]  cnt0;
    logic [15:0] idx0;
    logic [1:0]  st0;

    logic        cost_ready9, prune9, busy9, done9;
    logic [8:0]  min9;
    logic [3:0]  cnt9;
    logic [15:0] idx9;
    logic [1:0]  st9;

    int n_total = 0;
    int n_bad   = 0;
    bit check_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    cost_min_tracker dut0 (
        .CLK(CLK), .RST(RST), .start(start), .cost_valid(cost_valid),
        .cost_in(cost_in), .cand_last(cand_last), .cost_ready(cost_ready0),
        .prune(prune0), .busy(busy0), .MinCost(min0), .MatchCount(cnt0),
        .MinIdx(idx0), .done(done0), .state_dbg(st0)
    );

    cost_min_tracker #(.SUM_W(9)) dut9 (
        .CLK(CLK), .RST(RST), .start(start), .cost_valid(cost_valid),
        .cost_in(cost_in), .cand_last(cand_last), .cost_ready(cost_ready9),
        .prune(prune9), .busy(busy9), .MinCost(min9), .MatchCount(cnt9),
        .MinIdx(idx9), .done(done9), .state_dbg(st9)
    );

    // ---------------- reference model ----------------
    int unsigned totals[$];   // raw (unsaturated) total per finished candidate
    bit          m_busy  = 0;
    bit          m_done  = 0;
    bit          m_last  = 0;
    int          m_items = 0; // items received for the current candidate
    int unsigned m_cur   = 0; // raw partial sum of the current candidate

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Results implied by the candidate totals seen so far in this session.
    task automatic results(input int unsigned mx, output int unsigned mn,
                           output int unsigned cnt, output int unsigned idx);
        int unsigned ties;
        mn = mx; cnt = 0; idx = 0; ties = 0;
        foreach (totals[i]) if (sat(totals[i], mx) < mn || i == 0) mn = sat(totals[i], mx);
        for (int i = totals.size() - 1; i >= 0; i--) begin
            if (sat(totals[i], mx) == mn) begin
                ties++;
                idx = i;
            end
        end
        cnt = (ties > 15) ? 15 : ties;
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            totals.delete();
            m_busy = 0; m_done = 0; m_last = 0; m_items = 0; m_cur = 0;
        end else if (!m_busy) begin
            if (start) begin
                totals.delete();
                m_done = 0; m_busy = 1; m_items = 0; m_cur = 0;
            end
        end else if (m_items < N) begin
            if (cost_valid) begin
                m_cur += cost_in;
                m_items++;
                if (m_items == N) m_last = cand_last;
            end
        end else begin
            totals.push_back(m_cur);
            if (m_last) begin
                m_busy = 0;
                m_done = 1;
            end else begin
                m_items = 0;
                m_cur   = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        int unsigned mn0, c0, i0, mn9, c9, i9;
        bit in_acc;
        if (check_en) begin
            results(1023, mn0, c0, i0);
            results(511, mn9, c9, i9);
            in_acc = m_busy && (m_items < N);
            chk("ready0", cost_ready0, in_acc);
            chk("busy0",  busy0, m_busy);
            chk("done0",  done0, m_done);
            chk("min0",   min0, mn0);
            chk("cnt0",   cnt0, c0);
            chk("idx0",   idx0, i0);
            chk("prune0", prune0, in_acc && totals.size() > 0 && sat(m_cur, 1023) > mn0);
            chk("ready9", cost_ready9, in_acc);
            chk("done9",  done9, m_done);
            chk("min9",   min9, mn9);
            chk("cnt9",   cnt9, c9);
            chk("idx9",   idx9, i9);
            chk("prune9", prune9, in_acc && totals.size() > 0 && sat(m_cur, 511) > mn9);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_session();
        @(negedge CLK);
        start = 1; cost_valid = 0;
        @(negedge CLK);
        start = 0;
    endtask

    // Sends the first n_send items of a candidate with random bubbles. When
    // the whole candidate is sent, it also drives junk data during the
    // compare cycle. probe_at > 0 pins prune after that many items.
    task automatic send_cand(input int unsigned costs[N], input bit last,
                             input int bubble_pct, input int n_send,
                             input int probe_at, input bit probe_exp);
        int i = 0;
        int g = 0;
        bit probed = 0;
        while (i < n_send) begin
            @(negedge CLK);
            if (probe_at > 0 && i == probe_at && !probed) begin
                chk("lit_prune", prune0, probe_exp);
                probed = 1;
            end
            g++;
            if (g > 400) begin
                chk("drive_timeout", 0, 1);
                return;
            end
            if ($urandom_range(99) < bubble_pct) begin
                cost_valid = 0;
                cost_in    = 7'($urandom_range(127));
            end else begin
                cost_valid = 1;
                cost_in    = 7'(costs[i]);
                cand_last  = (i == N - 1) ? last : 1'($urandom_range(1));
                if (cost_ready0) i++;
            end
        end
        if (n_send == N) begin
            @(negedge CLK);
            cost_valid = 1'($urandom_range(1));
            cost_in    = 7'($urandom_range(127));
            cand_last  = 1'($urandom_range(1));
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (done0 !== 1'b1 && g < 20) begin
            @(negedge CLK);
            g++;
        end
        chk("done_wait", done0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned c[N];
        int ncand;
        RST = 1; start = 0; cost_valid = 0; cost_in = 0; cand_last = 0;
        repeat (3) @(negedge CLK);
        chk("rst_min", min0, 1023);
        chk("rst_cnt", cnt0, 0);
        chk("rst_done", done0, 0);
        chk("rst_ready", cost_ready0, 0);
        @(negedge CLK);
        RST = 0;
        check_en = 1;

        // one candidate 1..8
        start_session();
        c = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_cand(c, 1, 0, N, 0, 0);
        wait_done();
        chk("lit_min36", min0, 36);
        chk("lit_cnt1", cnt0, 1);
        chk("lit_idx0", idx0, 0);

        // totals 40, 30, 30
        start_session();
        c = '{5, 5, 5, 5, 5, 5, 5, 5};
        send_cand(c, 0, 20, N, 0, 0);
        c = '{2, 4, 6, 8, 2, 4, 2, 2};
        send_cand(c, 0, 20, N, 4, 0);
        c = '{4, 4, 4, 4, 4, 4, 3, 3};
        send_cand(c, 1, 20, N, 0, 0);
        wait_done();
        chk("lit_min30", min0, 30);
        chk("lit_cnt2", cnt0, 2);
        chk("lit_idx1", idx0, 1);

        // prune once a partial sum passes an established minimum of 30
        start_session();
        c = '{4, 4, 4, 4, 4, 4, 3, 3};
        send_cand(c, 0, 0, N, 0, 0);
        c = '{10, 10, 10, 10, 10, 10, 10, 10};
        send_cand(c, 1, 0, N, 4, 1);
        wait_done();
        chk("lit_min30b", min0, 30);

        // full-scale costs; dut9 saturates at 511
        start_session();
        c = '{127, 127, 127, 127, 127, 127, 127, 127};
        send_cand(c, 0, 0, N, 0, 0);
        send_cand(c, 1, 30, N, 0, 0);
        wait_done();
        chk("lit_min1016", min0, 1016);
        chk("lit_cnt_full", cnt0, 2);
        chk("lit_min511", min9, 511);
        chk("lit_cnt_sat9", cnt9, 2);

        // 17 equal candidates: count saturates at 15
        start_session();
        c = '{2, 3, 2, 3, 2, 3, 2, 3};
        for (int k = 0; k < 17; k++) send_cand(c, k == 16, 10, N, 0, 0);
        wait_done();
        chk("lit_cnt15", cnt0, 15);
        chk("lit_idx_tie", idx0, 0);
        chk("lit_min20", min0, 20);

        // random sessions; the last uses tiny costs to force ties
        for (int s = 0; s < 4; s++) begin
            start_session();
            ncand = $urandom_range(6, 2);
            for (int k = 0; k < ncand; k++) begin
                foreach (c[j]) c[j] = (s == 3) ? $urandom_range(2) : $urandom_range(127);
                send_cand(c, k == ncand - 1, 40, N, 0, 0);
            end
            wait_done();
        end

        // reset after item 5 of candidate 2
        start_session();
        foreach (c[j]) c[j] = $urandom_range(127);
        send_cand(c, 0, 0, N, 0, 0);
        send_cand(c, 1, 0, 5, 0, 0);
        @(negedge CLK);
        #2 RST = 1; cost_valid = 0;
        @(negedge CLK);
        chk("mid_rst_min", min0, 1023);
        chk("mid_rst_cnt", cnt0, 0);
        chk("mid_rst_idx", idx0, 0);
        chk("mid_rst_done", done0, 0);
        chk("mid_rst_busy", busy0, 0);
        #2 RST = 0;

        start_session();
        c = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_cand(c, 1, 25, N, 0, 0);
        wait_done();
        chk("post_rst_min", min0, 36);
        chk("post_rst_cnt", cnt0, 1);

        @(negedge CLK);
        cost_valid = 0;
        repeat (3) @(negedge CLK);
        check_en = 0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cost_min_tracker.md
Name: cost_min_tracker

Overview:
- Streaming cost evaluator for assignment-style searches. An upstream candidate generator presents each candidate as N_ITEMS cost values. The block accumulates each candidate's total, tracks the minimum total, the number of candidates that reach it, and the index of the first candidate to reach it.
- Generalises the fixed 8-item/7-bit cost evaluator:
  - parametrised item count and widths;
  - valid/ready input handshake;
  - multi-candidate session;
  - winning-index capture;
  - saturating arithmetic;
  - early prune hint.

Parameters:
- N_ITEMS, 8: cost values per candidate (≥2).
- COST_W, 7: width of one cost value.
- SUM_W, 10: accumulator and MinCost width.
- CNT_W, 4: MatchCount width.
- IDX_W, 16: candidate index width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  begins a new session; sampled only in IDLE.
- cost_valid  in  1  cost_in is valid this cycle.
- cost_in  in  COST_W  one item cost, unsigned.
- cand_last  in  1  marks the current candidate as the session's final one; sampled with the candidate's last item.
- cost_ready  out  1  block accepts cost_in this cycle.
- prune  out  1  the current partial sum already exceeds MinCost.
- busy  out  1  session in progress.
- MinCost  out  SUM_W  minimum candidate total.
- MatchCount  out  CNT_W  number of candidates equal to MinCost.
- MinIdx  out  IDX_W  index of the first candidate that achieved MinCost.
- done  out  1  session complete; results valid.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE;
  - MinCost = all ones; MatchCount=0; MinIdx=0; done=0;
  - internal sum, item counter, candidate index, found flag and last flag all cleared.
- States: IDLE, ACC, CMP.
- IDLE:
  - cost_ready=0, busy=0.
  - On start=1: done<=0, MinCost<=all ones, MatchCount<=0, MinIdx<=0, cand_idx<=0, sum<=0, item<=0, found<=0. Go to ACC.
  - cost_valid in IDLE is ignored.
- ACC:
  - cost_ready=1, busy=1.
  - A transfer occurs when cost_valid=1 in ACC. On each transfer:
    - sum <= sum + zero-extended cost_in, saturating at 2^SUM_W-1;
    - item <= item+1.
  - Transfer with item==N_ITEMS-1: latch cand_last into the last flag, go to CMP.
  - cand_last is ignored on all other items.
  - A cost_valid=0 cycle inserts a bubble; no state change.
- CMP (exactly one cycle):
  - cost_ready=0, busy=1. Compare sum against MinCost:
    - found==0 or sum<MinCost: MinCost<=sum, MatchCount<=1, MinIdx<=cand_idx, found<=1.
    - otherwise, if sum==MinCost: MatchCount<=MatchCount+1, saturating at 2^CNT_W-1. MinIdx is unchanged.
    - otherwise (sum>MinCost): no change.
  - Then:
    - if last flag set: done<=1, go to IDLE;
    - else: sum<=0, item<=0, cand_idx<=cand_idx+1 (saturating at 2^IDX_W-1), go to ACC.
- The first candidate always loads, even if its saturated sum equals the initial all-ones MinCost; MatchCount is then 1.
- Throughput: N_ITEMS+1 cycles per candidate with no bubbles.
- Latency: results and done update on the edge following the final item's transfer.
- done behaviour:
  - stays 1 in IDLE until the next accepted start;
  - results hold until that start;
  - clears on the same edge that accepts start.
- prune = (state==ACC) && found && (sum > MinCost). Combinational from registers; informational only. The block still requires all N_ITEMS items of the candidate.
- start is ignored in ACC and CMP.
- RST asserted mid-session aborts immediately to reset values; no done pulse.

Test Plan:
- Defaults; start, 1 candidate of eight costs 1..8, cand_last on item 8 → done=1 one cycle after the 8th transfer; MinCost=36, MatchCount=1, MinIdx=0.
- 3 candidates with totals 40, 30, 30 (last on the third) → MinCost=30, MatchCount=2, MinIdx=1. Also check prune=1 during candidate 2 or 3 once the partial sum exceeds 40 is not reached (remains 0). Check prune=1 while a 4th-run candidate's partial sum reaches 31+ in a follow-up session seeded with MinCost=30.
- Eight costs of 127 (sum 1016) followed by a candidate of eight costs of 127 plus bubbles → sum stays 1016; MatchCount=2. With SUM_W=9, the sum saturates at 511 with no wrap.
- 17 candidates all totalling 20 with CNT_W=4 → MatchCount saturates at 15; MinIdx=0.
- Random cost_valid bubbles, and cost_valid asserted during CMP → CMP-cycle data not consumed; totals match the reference model.
- RST pulse after item 5 of candidate 2 → all outputs return to reset values, done=0. A new start runs a clean session.
